// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the pipeline stage record for the WB-side register file.
package wb_regfile_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM_LOG2 = 5;

  localparam logic [REG_BUS-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_BUS-1:0] REG_ZERO_ADDR = 5'd0;
  localparam logic                    WRITE_ENABLE  = 1'b1;
  localparam logic                    READ_ENABLE   = 1'b1;

  typedef logic [REG_BUS-1:0]      reg_t;
  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  // One in-flight result as carried by the MEM and WB registers.
  typedef struct packed {
    reg_addr_t wd;
    logic      wreg;
    reg_t      wdata;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic logic stage_hit(input stage_t s, input reg_addr_t addr);
    return (s.wreg == WRITE_ENABLE) && (s.wd == addr);
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// GPR storage: one synchronous write port, two asynchronous read ports, async clear.
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_t      wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output reg_t      rdata1,
  output reg_t      rdata2
);

  reg_t mem [NREG];

  // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= ZERO_WORD;
    end else if (we && waddr != REG_ZERO_ADDR && 32'(waddr) < NREG) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZERO_WORD;
    rdata2 = ZERO_WORD;
    if (raddr1 != REG_ZERO_ADDR && 32'(raddr1) < NREG) rdata1 = mem[raddr1];
    if (raddr2 != REG_ZERO_ADDR && 32'(raddr2) < NREG) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// EX->MEM->WB result pipeline retiring into the GPR file, with fully forwarded read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int FWD_EX = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t ex_wd_i,
  input  logic      ex_wreg_i,
  input  reg_t      ex_wdata_i,
  input  logic      stall_i,
  input  logic      flush_i,
  input  logic      re1_i,
  input  reg_addr_t raddr1_i,
  input  logic      re2_i,
  input  reg_addr_t raddr2_i,
  output reg_t      rdata1_o,
  output reg_t      rdata2_o,
  output reg_addr_t wb_wd_o,
  output logic      wb_wreg_o,
  output reg_t      wb_wdata_o
);

  stage_t ex_s, mem_q, wb_q;
  reg_t   arr_rdata1, arr_rdata2;

  assign ex_s = '{wd: ex_wd_i, wreg: ex_wreg_i, wdata: ex_wdata_i};

  // NOTE: pipeline state uses non-blocking assignments so WB captures MEM's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (flush_i) begin
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (stall_i) begin
      wb_q  <= BUBBLE;
    end else begin
      mem_q <= ex_s;
      wb_q  <= mem_q;
    end
  end

  // Retirement happens from the old WB contents regardless of stall/flush.
  wb_regfile_array #(.NREG(NREG)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_q.wreg),
    .waddr  (wb_q.wd),
    .wdata  (wb_q.wdata),
    .raddr1 (raddr1_i),
    .raddr2 (raddr2_i),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  function automatic reg_t fwd_read(input logic re, input reg_addr_t addr, input reg_t arr,
                                    input stage_t ex, input stage_t mem, input stage_t wb);
    if (re != READ_ENABLE || addr == REG_ZERO_ADDR) return ZERO_WORD;
    if (FWD_EX != 0 && stage_hit(ex, addr))         return ex.wdata;
    if (stage_hit(mem, addr))                       return mem.wdata;
    if (stage_hit(wb, addr))                        return wb.wdata;
    return arr;
  endfunction

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    rdata1_o = ZERO_WORD;
    rdata2_o = ZERO_WORD;
    if (rst) begin
      rdata1_o = fwd_read(re1_i, raddr1_i, arr_rdata1, ex_s, mem_q, wb_q);
      rdata2_o = fwd_read(re2_i, raddr2_i, arr_rdata2, ex_s, mem_q, wb_q);
    end
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench: two DUTs (EX forwarding on/off) compared each cycle against a model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        stall, flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;

  logic [31:0] fx_rdata1, fx_rdata2, fx_wb_wdata;
  logic [4:0]  fx_wb_wd;
  logic        fx_wb_wreg;
  logic [31:0] nf_rdata1, nf_rdata2, nf_wb_wdata;
  logic [4:0]  nf_wb_wd;
  logic        nf_wb_wreg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_regfile #(.NREG(32), .FWD_EX(1)) dut_fx (
    .clk(clk), .rst(rst),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata),
    .stall_i(stall), .flush_i(flush),
    .re1_i(re1), .raddr1_i(raddr1), .re2_i(re2), .raddr2_i(raddr2),
    .rdata1_o(fx_rdata1), .rdata2_o(fx_rdata2),
    .wb_wd_o(fx_wb_wd), .wb_wreg_o(fx_wb_wreg), .wb_wdata_o(fx_wb_wdata)
  );

  wb_regfile #(.NREG(32), .FWD_EX(0)) dut_nf (
    .clk(clk), .rst(rst),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata),
    .stall_i(stall), .flush_i(flush),
    .re1_i(re1), .raddr1_i(raddr1), .re2_i(re2), .raddr2_i(raddr2),
    .rdata1_o(nf_rdata1), .rdata2_o(nf_rdata2),
    .wb_wd_o(nf_wb_wd), .wb_wreg_o(nf_wb_wreg), .wb_wdata_o(nf_wb_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a two-slot in-flight list plus a register array.
  typedef struct { logic [4:0] wd; logic wreg; logic [31:0] wdata; } res_t;
  localparam res_t NONE = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0};

  res_t        m_mem = NONE;
  res_t        m_wb  = NONE;
  logic [31:0] m_gpr [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mem <= NONE;
      m_wb  <= NONE;
      for (int i = 0; i < 32; i++) m_gpr[i] <= 32'd0;
    end else begin
      if (m_wb.wreg && m_wb.wd != 5'd0) m_gpr[m_wb.wd] <= m_wb.wdata;
      if (flush) begin
        m_mem <= NONE;
        m_wb  <= NONE;
      end else if (stall) begin
        m_wb  <= NONE;
      end else begin
        m_wb  <= m_mem;
        m_mem <= '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};
      end
    end
  end

  // Youngest pending writer of addr wins; otherwise the committed value.
  function automatic logic [31:0] m_read(input logic re, input logic [4:0] addr, input bit fwd_ex);
    res_t pend [$];
    if (!rst || !re || addr == 5'd0) return 32'd0;
    if (fwd_ex) pend.push_back('{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata});
    pend.push_back(m_mem);
    pend.push_back(m_wb);
    foreach (pend[i]) if (pend[i].wreg && pend[i].wd == addr) return pend[i].wdata;
    return m_gpr[addr];
  endfunction

  always @(negedge clk) begin
    check("fx_rdata1", fx_rdata1, m_read(re1, raddr1, 1'b1));
    check("fx_rdata2", fx_rdata2, m_read(re2, raddr2, 1'b1));
    check("nf_rdata1", nf_rdata1, m_read(re1, raddr1, 1'b0));
    check("nf_rdata2", nf_rdata2, m_read(re2, raddr2, 1'b0));
    check("fx_wb_wd",    {27'd0, fx_wb_wd},   {27'd0, m_wb.wd});
    check("fx_wb_wreg",  {31'd0, fx_wb_wreg}, {31'd0, m_wb.wreg});
    check("fx_wb_wdata", fx_wb_wdata,         m_wb.wdata);
    check("nf_wb_wreg",  {31'd0, nf_wb_wreg}, {31'd0, m_wb.wreg});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic w, input logic [4:0] d, input logic [31:0] v);
    ex_wreg  = w;
    ex_wd    = d;
    ex_wdata = v;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    re1 = 1'b1; raddr1 = a1;
    re2 = 1'b1; raddr2 = a2;
  endtask

  initial begin
    rst = 1'b1;
    drive_ex(1'b0, 5'd0, 32'd0);
    stall = 1'b0; flush = 1'b0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    rd(5'd5, 5'd5);
    #1;
    check("reset_wb_wreg", {31'd0, fx_wb_wreg}, 32'd0);
    check("reset_rdata1", fx_rdata1, 32'd0);

    // Retire r5
    drive_ex(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("t2_fx_ex_fwd", fx_rdata1, 32'hDEADBEEF);
    check("t2_nf_no_ex_fwd", nf_rdata1, 32'd0);
    tick(); drive_ex(1'b0, 5'd0, 32'd0); #1;
    check("t2_nf_mem_fwd", nf_rdata1, 32'hDEADBEEF);
    check("t2_edge1_wb_wreg", {31'd0, fx_wb_wreg}, 32'd0);
    tick(); #1;
    check("t2_edge2_wb_wd", {27'd0, fx_wb_wd}, 32'd5);
    check("t2_edge2_wb_wreg", {31'd0, fx_wb_wreg}, 32'd1);
    check("t2_edge2_wb_wdata", fx_wb_wdata, 32'hDEADBEEF);
    tick(); #1;
    check("t2_edge3_wb_wreg", {31'd0, fx_wb_wreg}, 32'd0);
    check("t2_gpr5", nf_rdata1, 32'hDEADBEEF);

    // Forward priority on r7
    rd(5'd7, 5'd7);
    drive_ex(1'b1, 5'd7, 32'd1); tick();
    drive_ex(1'b1, 5'd7, 32'd2); tick();
    drive_ex(1'b1, 5'd7, 32'd3); #1;
    check("t3_fx_ex_wins", fx_rdata1, 32'd3);
    check("t3_fx_port2_same", fx_rdata2, 32'd3);
    check("t3_nf_mem_wins", nf_rdata1, 32'd2);
    tick(); drive_ex(1'b0, 5'd0, 32'd0); #1;
    check("t3_nf_mem3", nf_rdata1, 32'd3);
    repeat (3) tick();
    #1;
    check("t3_gpr7", nf_rdata1, 32'd3);

    // $0 is never written nor forwarded
    rd(5'd0, 5'd0);
    drive_ex(1'b1, 5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive_ex(1'b0, 5'd0, 32'd0);
      #1;
      check("t4_fx_r0_p1", fx_rdata1, 32'd0);
      check("t4_nf_r0_p2", nf_rdata2, 32'd0);
      tick();
    end
    re1 = 1'b0; raddr1 = 5'd7; #1;
    check("t4_re_off", fx_rdata1, 32'd0);

    // Stall holds r9 in MEM
    rd(5'd9, 5'd10);
    drive_ex(1'b1, 5'd9, 32'hA5); tick();
    stall = 1'b1;
    drive_ex(1'b1, 5'd10, 32'h77); #1;
    check("t5_fx_r9", fx_rdata1, 32'hA5);
    check("t5_fx_r10_ex", fx_rdata2, 32'h77);
    check("t5_nf_r10", nf_rdata2, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("t5_stall_bubble", {31'd0, fx_wb_wreg}, 32'd0);
      check("t5_stall_r9", nf_rdata1, 32'hA5);
    end
    stall = 1'b0;
    drive_ex(1'b0, 5'd0, 32'd0);
    tick(); #1;
    check("t5_retire_wd", {27'd0, fx_wb_wd}, 32'd9);
    check("t5_retire_wreg", {31'd0, fx_wb_wreg}, 32'd1);
    check("t5_retire_wdata", fx_wb_wdata, 32'hA5);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("t5_once", {31'd0, fx_wb_wreg}, 32'd0);
      check("t5_gpr9", nf_rdata1, 32'hA5);
    end
    check("t5_r10_dropped", nf_rdata2, 32'd0);

    // Flush beats stall
    rd(5'd4, 5'd4);
    drive_ex(1'b1, 5'd4, 32'h55); tick();
    drive_ex(1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    #1;
    check("t6_prior_r4", nf_rdata1, 32'h55);
    drive_ex(1'b1, 5'd4, 32'h11); tick();
    stall = 1'b1; flush = 1'b1;
    drive_ex(1'b0, 5'd0, 32'd0); #1;
    check("t6_mem_fwd", nf_rdata1, 32'h11);
    tick();
    stall = 1'b0; flush = 1'b0; #1;
    check("t6_flushed_wb", {31'd0, fx_wb_wreg}, 32'd0);
    check("t6_flushed_rd", nf_rdata1, 32'h55);
    repeat (3) tick();
    #1;
    check("t6_r4_kept", fx_rdata2, 32'h55);

    // Mid-run reset
    rd(5'd3, 5'd3);
    drive_ex(1'b1, 5'd3, 32'h1234); tick();
    drive_ex(1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    #1;
    check("t1_r3_set", nf_rdata1, 32'h1234);
    drive_ex(1'b1, 5'd6, 32'hCAFE);
    tick(); tick(); #1;
    check("t1_wb_busy", {31'd0, fx_wb_wreg}, 32'd1);
    rst = 1'b0; #1;
    check("t1_rst_rdata1", nf_rdata1, 32'd0);
    check("t1_rst_fx_rdata2", fx_rdata2, 32'd0);
    check("t1_rst_wb_wreg", {31'd0, fx_wb_wreg}, 32'd0);
    check("t1_rst_wb_wdata", fx_wb_wdata, 32'd0);
    tick(); #1;
    check("t1_rst_hold", nf_rdata1, 32'd0);
    rst = 1'b1;
    drive_ex(1'b0, 5'd0, 32'd0); #1;
    check("t1_after_r3", nf_rdata1, 32'd0);
    rd(5'd6, 5'd3);
    tick(); tick(); #1;
    check("t1_after_r6", fx_rdata1, 32'd0);
    check("t1_after_r3_p2", fx_rdata2, 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
